// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive path: element encoding, default
// thresholds, FSM states and ASCII constants.
package morse_pkg;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  localparam int DASH_MIN_DEF = 2;
  localparam int CHAR_GAP_DEF = 3;
  localparam int WORD_GAP_DEF = 7;
  localparam int CNT_W_DEF    = 4;
  localparam int MAX_ELEMS    = 5;

  typedef enum logic [1:0] {IDLE, MARK, GAP} state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  // Keep only the len_i valid elements of a code word.
  function automatic logic [4:0] mask_code(input logic [2:0] len_i, input logic [4:0] code_i);
    return code_i & ~(5'h1F << len_i);
  endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Character output channel of the Morse decoder: valid/ready byte stream plus
// error and overrun pulses.
interface morse_decoder_if;
  logic [7:0] out_ascii;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic       overrun;

  modport master (output out_ascii, output out_valid, output err, output overrun,
                  input out_ready);
  modport slave  (input out_ascii, input out_valid, input err, input overrun,
                  output out_ready);
endinterface

// File: rtl/morse_lut.sv
// Combinational International Morse lookup: {len, code} -> {hit, ascii}.
// Code holds the first element in the most significant valid bit, dash = 1.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] len_i,
  input  logic [4:0] code_i,
  output logic       hit_o,
  output logic [7:0] ascii_o
);

  logic [4:0] code_m;

  always_comb begin
    code_m  = mask_code(len_i, code_i);
    hit_o   = 1'b1;
    ascii_o = ASCII_NUL;
    case ({len_i, code_m})
      8'b010_00001: ascii_o = "A";
      8'b100_01000: ascii_o = "B";
      8'b100_01010: ascii_o = "C";
      8'b011_00100: ascii_o = "D";
      8'b001_00000: ascii_o = "E";
      8'b100_00010: ascii_o = "F";
      8'b011_00110: ascii_o = "G";
      8'b100_00000: ascii_o = "H";
      8'b010_00000: ascii_o = "I";
      8'b100_00111: ascii_o = "J";
      8'b011_00101: ascii_o = "K";
      8'b100_00100: ascii_o = "L";
      8'b010_00011: ascii_o = "M";
      8'b010_00010: ascii_o = "N";
      8'b011_00111: ascii_o = "O";
      8'b100_00110: ascii_o = "P";
      8'b100_01101: ascii_o = "Q";
      8'b011_00010: ascii_o = "R";
      8'b011_00000: ascii_o = "S";
      8'b001_00001: ascii_o = "T";
      8'b011_00001: ascii_o = "U";
      8'b100_00001: ascii_o = "V";
      8'b011_00011: ascii_o = "W";
      8'b100_01001: ascii_o = "X";
      8'b100_01011: ascii_o = "Y";
      8'b100_01100: ascii_o = "Z";
      8'b101_11111: ascii_o = "0";
      8'b101_01111: ascii_o = "1";
      8'b101_00111: ascii_o = "2";
      8'b101_00011: ascii_o = "3";
      8'b101_00001: ascii_o = "4";
      8'b101_00000: ascii_o = "5";
      8'b101_10000: ascii_o = "6";
      8'b101_11000: ascii_o = "7";
      8'b101_11100: ascii_o = "8";
      8'b101_11110: ascii_o = "9";
      default:      hit_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: classifies key marks/gaps per tick and emits ASCII through a
// single-entry valid/ready register. Define MORSE_WORD_SPACE_EN to emit 8'h20 on word gaps.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DASH_MIN = DASH_MIN_DEF,
  parameter int CHAR_GAP = CHAR_GAP_DEF,
  parameter int WORD_GAP = WORD_GAP_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             key_in,
  morse_decoder_if.master  out_bus
);

  localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] CHAR_GAP_C = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] WORD_GAP_C = CNT_W'(WORD_GAP);

  state_e           state_q;
  logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [4:0]       code_q;
  logic [2:0]       len_q;
  logic             ovf_q;
  logic [7:0]       ascii_q;
  logic             valid_q, err_q, overrun_q;

  logic             lut_hit;
  logic [7:0]       lut_ascii;
  logic             is_dash, char_evt, word_evt, char_ok, char_bad;
  logic             load_req, accept;
  logic [7:0]       load_byte;

  morse_lut u_lut (
    .len_i   (len_q),
    .code_i  (code_q),
    .hit_o   (lut_hit),
    .ascii_o (lut_ascii)
  );

  always_comb begin
    mark_cnt_d = (&mark_cnt_q) ? mark_cnt_q : mark_cnt_q + 1'b1;
    gap_cnt_d  = (&gap_cnt_q)  ? gap_cnt_q  : gap_cnt_q + 1'b1;
    is_dash    = (mark_cnt_q >= DASH_MIN_C) ? ELEM_DASH : ELEM_DOT;
    // Events fire only on the tick where the gap count first reaches a threshold.
    char_evt   = tick & ~key_in & (state_q == GAP) &
                 (gap_cnt_d == CHAR_GAP_C) & (gap_cnt_q != CHAR_GAP_C);
    word_evt   = tick & ~key_in & (state_q == GAP) &
                 (gap_cnt_d == WORD_GAP_C) & (gap_cnt_q != WORD_GAP_C);
    char_ok    = char_evt & lut_hit & ~ovf_q;
    char_bad   = char_evt & (~lut_hit | ovf_q);
`ifdef MORSE_WORD_SPACE_EN
    load_req   = char_ok | word_evt;
    load_byte  = word_evt ? ASCII_SPACE : lut_ascii;
`else
    load_req   = char_ok;
    load_byte  = lut_ascii;
`endif
    accept     = valid_q & out_bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mark_cnt_q <= '0;
      gap_cnt_q  <= '0;
      code_q     <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      ascii_q    <= ASCII_NUL;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      err_q     <= char_bad;
      overrun_q <= load_req & valid_q & ~out_bus.out_ready;

      // Reload in the same cycle as an accept so back-to-back bytes need no bubble.
      if (load_req && (!valid_q || out_bus.out_ready)) begin
        ascii_q <= load_byte;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (tick) begin
        case (state_q)
          IDLE: begin
            if (key_in) begin
              state_q    <= MARK;
              mark_cnt_q <= CNT_W'(1);
            end
          end
          MARK: begin
            if (key_in) begin
              mark_cnt_q <= mark_cnt_d;
            end else begin
              if (len_q == 3'(MAX_ELEMS)) begin
                ovf_q <= 1'b1;
              end else begin
                code_q <= {code_q[3:0], is_dash};
                len_q  <= len_q + 1'b1;
              end
              gap_cnt_q <= CNT_W'(1);
              state_q   <= GAP;
            end
          end
          GAP: begin
            if (key_in) begin
              state_q    <= MARK;
              mark_cnt_q <= CNT_W'(1);
            end else begin
              gap_cnt_q <= gap_cnt_d;
              if (char_evt) begin
                code_q <= '0;
                len_q  <= '0;
                ovf_q  <= 1'b0;
              end
              if (word_evt) state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_bus.out_ascii = ascii_q;
  assign out_bus.out_valid = valid_q;
  assign out_bus.err       = err_q;
  assign out_bus.overrun   = overrun_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: expected bytes are queued as keying is
// driven and compared when the consumer accepts them.
module tb_morse_decoder;
  import morse_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic key_in = 1'b0;

  always #5 clk = ~clk;

  morse_decoder_if bus();

  morse_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .key_in  (key_in),
    .out_bus (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int err_seen = 0, err_exp = 0;
  int ovr_seen = 0, ovr_exp = 0;
  logic [7:0] exp_q[$];

  string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----."};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.err) err_seen++;
      if (bus.overrun) ovr_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("spurious_char", {24'b0, bus.out_ascii}, 32'hFFFF_FFFF);
        else check("char", {24'b0, bus.out_ascii}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic tk(input logic k);
    key_in = k;
    tick   = 1'b1;
    @(posedge clk); #1;
    tick   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Dot = 1 mark tick, dash = 3; 1-tick element gaps; 3 low ticks close the character.
  task automatic send_code(input string s);
    for (int i = 0; i < s.len(); i++) begin
      repeat ((s[i] == "-") ? 3 : 1) tk(1'b1);
      if (i < s.len() - 1) tk(1'b0);
    end
    repeat (3) tk(1'b0);
  endtask

  task automatic end_test(input string name);
    idle(6);
    check({name, "_q_empty"}, exp_q.size(), 0);
    check({name, "_err"}, err_seen, err_exp);
    check({name, "_ovr"}, ovr_seen, ovr_exp);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, {31'b0, bus.out_valid}, 0);
    check({name, "_ascii"}, {24'b0, bus.out_ascii}, 0);
    check({name, "_err"}, {31'b0, bus.err}, 0);
    check({name, "_ovr"}, {31'b0, bus.overrun}, 0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    idle(3);
    check_reset_outputs("rst0");
    rst = 1'b0;
    idle(2);

    // "A" with the literal key sequence
    exp_q.push_back(8'h41);
    tk(1); tk(0); tk(1); tk(1); tk(1); tk(0); tk(0); tk(0);
    end_test("A");

    exp_q.push_back(8'h30);
    send_code("-----");
    end_test("zero");

    // 2-tick mark is the dash threshold; 20-tick mark exercises counter saturation
    exp_q.push_back(8'h54);
    tk(1); tk(1); tk(0); tk(0); tk(0);
    exp_q.push_back(8'h54);
    repeat (20) tk(1);
    repeat (3) tk(0);
    end_test("dash_bound");

    // Backpressure: E held, T dropped with overrun
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h45);
    send_code(".");
    send_code("-");
    ovr_exp++;
    idle(2);
    check("bp_valid", {31'b0, bus.out_valid}, 1);
    check("bp_hold", {24'b0, bus.out_ascii}, 32'h45);
    bus.out_ready = 1'b1;
    idle(3);
    check("bp_drained", {31'b0, bus.out_valid}, 0);
    end_test("bp");

    // Six elements and an undefined 4-element code both raise err only
    send_code("......");
    err_exp++;
    idle(2);
    check("ovf_valid", {31'b0, bus.out_valid}, 0);
    send_code("..--");
    err_exp++;
    end_test("err");

    // Word gap after E
    exp_q.push_back(8'h45);
`ifdef MORSE_WORD_SPACE_EN
    exp_q.push_back(ASCII_SPACE);
`endif
    send_code(".");
    repeat (4) tk(0);
    end_test("word");

    // Reset with a pending byte and a half-keyed "U"
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h45);
    send_code(".");
    tk(1); tk(0); tk(1); tk(0);
    rst = 1'b1;
    exp_q.delete();
    idle(1);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);
    exp_q.push_back(8'h45);
    send_code(".");
    end_test("after_rst");

    for (int i = 0; i < 36; i++) begin
      exp_q.push_back(chars[i]);
      send_code(codes[i]);
    end
    end_test("table");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
